// File: rtl/radix4_booth_mult.sv
// radix4_booth_mult: sequential radix-4 Booth multiplier, two product bits per ITER cycle.
// Ports: clk, rst_n (sync, active-low), start/mcand/mplier (request + operands),
//        busy (iterating), done (1-cycle result pulse), product (held until next done).
// Config: define RADIX4_UNSIGNED_EN for unsigned operands (one extra iteration);
//         default build treats operands as two's-complement signed.
module radix4_booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef RADIX4_UNSIGNED_EN
  // Two zero guard bits above the multiplier make the final recode see a
  // positive top digit, so an extra iteration consumes them.
  localparam int QW = WIDTH + 2;
  localparam int N  = WIDTH / 2 + 1;
`else
  localparam int QW = WIDTH;
  localparam int N  = WIDTH / 2;
`endif
  localparam int AW = WIDTH + 2;           // room for +/-2M without overflow
  localparam int CW = $clog2(N + 1);
  localparam int AL = 2 * WIDTH - QW;      // accumulator bits that land in product

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   a, m, pp, sum, a_nxt;
  logic [QW-1:0]   q, q_nxt;
  logic            q_m1;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            accept;

  assign last   = (cnt == CW'(N - 1));
  // start only counts outside ITER; a request while iterating is dropped.
  assign accept = start && (state != ITER);
  assign busy   = (state == ITER);
  assign done   = (state == DONE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? ITER : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- Booth recode + add + shift ----------------
  always_comb begin
    pp = '0;
    case ({q[1:0], q_m1})
      3'b001, 3'b010: pp = m;
      3'b011:         pp = {m[AW-2:0], 1'b0};
      3'b100:         pp = -{m[AW-2:0], 1'b0};
      3'b101, 3'b110: pp = -m;
      default:        pp = '0;
    endcase
    sum   = a + pp;
    // Arithmetic shift of {A,Q,q_m1} by two: A's sign fills from the top,
    // the two low sum bits drop into Q, and Q[1] becomes the new guard bit.
    a_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nxt = {sum[1:0], q[QW-1:2]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      a    <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
`ifdef RADIX4_UNSIGNED_EN
      m    <= {2'b00, mcand};
      q    <= {2'b00, mplier};
`else
      m    <= {{2{mcand[WIDTH-1]}}, mcand};
      q    <= mplier;
`endif
    end else if (state == ITER) begin
      a    <= a_nxt;
      q    <= q_nxt;
      q_m1 <= q[1];
      cnt  <= cnt + CW'(1);
      if (last) product <= {a_nxt[AL-1:0], q_nxt};
    end
  end

endmodule

// File: tb/tb_radix4_booth_mult.sv
// tb_radix4_booth_mult: randomized + directed bench for radix4_booth_mult.
// Ports: none; drives the DUT on posedge+1 and samples there as well.
// Config: honours RADIX4_UNSIGNED_EN for the reference model and iteration count.
module tb_radix4_booth_mult;
  localparam int W = 8;
`ifdef RADIX4_UNSIGNED_EN
  localparam int N = W / 2 + 1;
`else
  localparam int N = W / 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     mcand, mplier;
  logic             busy, done;
  logic [2*W-1:0]   product;

  int               n_checks = 0;
  int               n_err = 0;
  logic [2*W-1:0]   last_prod;

  always #5 clk = ~clk;

  radix4_booth_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp_v);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
`ifdef RADIX4_UNSIGNED_EN
    r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
`else
    r = $signed(x) * $signed(y);
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    mcand  = x;
    mplier = y;
    start  = 1'b1;
  endtask

  // Takes the accepting edge, scrambles the operand inputs, optionally pokes
  // start mid-iteration, and stops in the cycle where done is high.
  task automatic finish(input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    int busy_cycles = 0;
    int guard = 0;
    logic [2*W-1:0] exp_p;
    exp_p = model(x, y);
    tick();
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
    check("busy_after_start", busy, 1);
    check("prod_hold", product, last_prod);
    while (!done && guard < 50) begin
      if (busy) busy_cycles++;
      start = poke && (busy_cycles == 1);
      if (start) begin
        mcand  = W'($urandom);
        mplier = W'($urandom);
      end
      tick();
      guard++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("busy_cycles", busy_cycles, N);
    check("busy_in_done", busy, 0);
    check("product", product, exp_p);
    last_prod = exp_p;
  endtask

  task automatic idle_after();
    start = 1'b0;
    tick();
    check("done_pulse_len", done, 0);
    check("busy_idle", busy, 0);
    check("prod_held_idle", product, last_prod);
  endtask

  logic [W-1:0]   vx [4];
  logic [W-1:0]   vy [4];
  logic [2*W-1:0] vp [4];

  initial begin
    vx = '{8'h07, 8'h80, 8'h7F, 8'hFF};
    vy = '{8'hFD, 8'h80, 8'h7F, 8'hFF};
`ifdef RADIX4_UNSIGNED_EN
    vp = '{16'h06EB, 16'h4000, 16'h3F01, 16'hFE01};
`else
    vp = '{16'hFFEB, 16'h4000, 16'h3F01, 16'h0001};
`endif
    rst_n = 1'b0;
    start = 1'b1;              // must be ignored while in reset
    mcand = 8'h12;
    mplier = 8'h34;
    last_prod = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", busy, 0);

    // Directed vectors with hand-computed products.
    for (int i = 0; i < 4; i++) begin
      issue(vx[i], vy[i]);
      finish(vx[i], vy[i], 1'b0);
      check("spec_vector", product, vp[i]);
      idle_after();
    end

    // start during ITER must be ignored.
    issue(8'h07, 8'hFD);
    finish(8'h07, 8'hFD, 1'b1);
    idle_after();

    // Back-to-back: start held high in DONE.
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = W'($urandom);
      issue(x, y);
      finish(x, y, 1'b0);
    end
    idle_after();

    // Random operands, mixed idle gaps and chaining.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = W'($urandom);
      issue(x, y);
      finish(x, y, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_after();
    end
    idle_after();

    // Reset in the second ITER cycle aborts with no done pulse.
    begin
      int done_cnt = 0;
      int busy_cnt = 0;
      issue(8'h5A, 8'hC3);
      tick();
      start = 1'b0;
      tick();
      check("rst_mid_busy_before", busy, 1);
      rst_n = 1'b0;
      start = 1'b1;
      mcand = 8'h11;
      mplier = 8'h22;
      tick();
      rst_n = 1'b1;
      start = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_product", product, 0);
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done) done_cnt++;
        if (busy) busy_cnt++;
      end
      check("rst_mid_no_done", done_cnt, 0);
      check("rst_mid_no_busy", busy_cnt, 0);
      last_prod = '0;
    end

    issue(8'h80, 8'h7F);
    finish(8'h80, 8'h7F, 1'b0);
    idle_after();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
